// File: rtl/eq_pkg.sv
// ---------------------------------------------------------------------------
// eq_pkg
//   Shared definitions for the equalizer register-map front end.
//   - EQ_NUM_REGS / EQ_ADDR_W : register map geometry
//   - spi_state_t             : SPI frame-parser state encoding
//   - sat_inc8                : saturating byte increment used for the
//                               optional address auto-increment
// ---------------------------------------------------------------------------
package eq_pkg;

  localparam int EQ_NUM_REGS = 31;
  localparam int EQ_ADDR_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } spi_state_t;

  // Stops at 8'hFF so an auto-incrementing address can never wrap back
  // into the valid register range within one frame.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//   Brings one asynchronous pin into the clk domain through two flops and
//   keeps one further history flop for edge detection.
//   Ports:
//     clk      in  system clock
//     async_i  in  asynchronous input pin
//     level_o  out synchronised level
//     rise_o   out one-cycle pulse on a synchronised 0->1 transition
//     fall_o   out one-cycle pulse on a synchronised 1->0 transition
//   The flops carry no reset on purpose: they always track the pin, so a
//   reset applied while chip select is already low cannot fabricate a
//   falling edge once reset is released.
// ---------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk) begin
    meta_q <= async_i;
    sync_q <= meta_q;
    hist_q <= sync_q;
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~hist_q;
  assign fall_o  = ~sync_q & hist_q;

endmodule

// File: rtl/spi_reg_loader.sv
// ---------------------------------------------------------------------------
// spi_reg_loader
//   SPI-slave (mode 0, MSB first) front end that turns host frames of the
//   form {address byte, data byte 0..N} into single-cycle byte writes for
//   the equalizer register map. All SPI pins are oversampled in clk
//   (clk must run at least 4x sclk).
//
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     spi_sclk   in   SPI clock (asynchronous)
//     spi_cs_n   in   SPI chip select, active low (asynchronous)
//     spi_mosi   in   SPI serial data in (asynchronous)
//     we         out  one-cycle write strobe per accepted data byte
//     addr       out  write address, held until the next write
//     wr_data    out  write data, held until the next write
//     frame_end  out  one-cycle pulse after chip select releases an
//                     active frame
//     addr_err   out  one-cycle pulse when a data byte targets an address
//                     at or above NUM_REGS (no write is issued)
//
//   Build option: macro SPI_AUTOINC_EN
//     defined   - the frame address advances by one (saturating at 8'hFF)
//                 after every completed data byte
//     undefined - the frame address stays fixed for the whole frame
// ---------------------------------------------------------------------------
module spi_reg_loader
  import eq_pkg::*;
#(
  parameter int NUM_REGS   = EQ_NUM_REGS,
  parameter int ADDR_WIDTH = EQ_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [7:0]            wr_data,
  output logic                  frame_end,
  output logic                  addr_err
);

  localparam int PIN_SCLK = 0;
  localparam int PIN_CS   = 1;
  localparam int PIN_MOSI = 2;
  localparam int NUM_PINS = 3;

  // 9 bits so that NUM_REGS = 256 still compares correctly.
  localparam logic [8:0] NUM_REGS_LIM = 9'(NUM_REGS);

  // -------------------------------------------------------------------------
  // Pin synchronisation
  // -------------------------------------------------------------------------
  logic [NUM_PINS-1:0] pins;
  logic [NUM_PINS-1:0] level_s;
  logic [NUM_PINS-1:0] rise_s;
  logic [NUM_PINS-1:0] fall_s;

  assign pins[PIN_SCLK] = spi_sclk;
  assign pins[PIN_CS]   = spi_cs_n;
  assign pins[PIN_MOSI] = spi_mosi;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_sync
      sync_edge_det u_sync (
        .clk     (clk),
        .async_i (pins[gi]),
        .level_o (level_s[gi]),
        .rise_o  (rise_s[gi]),
        .fall_o  (fall_s[gi])
      );
    end
  endgenerate

  logic sclk_rise;
  logic cs_rise;
  logic cs_fall;
  logic cs_active;
  logic mosi_s;

  assign sclk_rise = rise_s[PIN_SCLK];
  assign cs_rise   = rise_s[PIN_CS];
  assign cs_fall   = fall_s[PIN_CS];
  assign cs_active = ~level_s[PIN_CS];
  assign mosi_s    = level_s[PIN_MOSI];

  logic unused_edges;
  assign unused_edges = ^{level_s[PIN_SCLK], fall_s[PIN_SCLK],
                          rise_s[PIN_MOSI], fall_s[PIN_MOSI]};

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  spi_state_t                state_q,     state_d;
  logic [2:0]                bit_cnt_q,   bit_cnt_d;
  logic [7:0]                shift_q,     shift_d;
  logic [7:0]                addr_q,      addr_d;
  logic                      we_q,        we_d;
  logic [ADDR_WIDTH-1:0]     wr_addr_q,   wr_addr_d;
  logic [7:0]                wr_data_q,   wr_data_d;
  logic                      frame_end_q, frame_end_d;
  logic                      addr_err_q,  addr_err_d;

  // Byte as it will look after the current sclk edge is shifted in; used
  // directly on the 8th edge so the write goes out one cycle later.
  logic [7:0] shift_nxt;
  logic       addr_in_range;

  assign shift_nxt     = {shift_q[6:0], mosi_s};
  assign addr_in_range = ({1'b0, addr_q} < NUM_REGS_LIM);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_end_d = 1'b0;
    addr_err_d  = 1'b0;

    if (cs_rise) begin
      // Frame closes: any partial byte is dropped.
      state_d     = IDLE;
      bit_cnt_d   = 3'd0;
      shift_d     = 8'd0;
      frame_end_d = (state_q != IDLE);
    end else if (cs_fall) begin
      // Covers both a fresh select from IDLE and a re-select mid-frame.
      state_d   = ADDR;
      bit_cnt_d = 3'd0;
      shift_d   = 8'd0;
    end else if (sclk_rise && cs_active && (state_q != IDLE)) begin
      shift_d   = shift_nxt;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        unique case (state_q)
          ADDR: begin
            addr_d  = shift_nxt;
            state_d = DATA;
          end
          DATA: begin
            if (addr_in_range) begin
              we_d      = 1'b1;
              wr_addr_d = ADDR_WIDTH'(addr_q);
              wr_data_d = shift_nxt;
            end else begin
              addr_err_d = 1'b1;
            end
`ifdef SPI_AUTOINC_EN
            addr_d = sat_inc8(addr_q);
`else
            addr_d = addr_q;
`endif
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      addr_q      <= 8'd0;
      we_q        <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      frame_end_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_end_q <= frame_end_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign we        = we_q;
  assign addr      = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign frame_end = frame_end_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_spi_reg_loader.sv
// ---------------------------------------------------------------------------
// tb_spi_reg_loader
//   Drives SPI frames into spi_reg_loader and compares every write strobe,
//   address error and frame-end pulse with a frame-level reference model.
// ---------------------------------------------------------------------------
module tb_spi_reg_loader;

  localparam int NREGS = 31;
`ifdef SPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       spi_sclk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wr_data;
  logic       frame_end;
  logic       addr_err;

  spi_reg_loader dut (
    .clk       (clk),
    .rst       (rst),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .we        (we),
    .addr      (addr),
    .wr_data   (wr_data),
    .frame_end (frame_end),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int last_rise_cyc = -100;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed events and model expectations for the current frame.
  logic [15:0] obs_wr[$];
  logic [15:0] exp_wr[$];
  int          obs_err = 0;
  int          obs_fe  = 0;
  int          exp_err = 0;
  logic [7:0]  hold_a  = 8'd0;
  logic [7:0]  hold_d  = 8'd0;
  logic [7:0]  frame_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Event monitor: pulses are sampled mid-cycle. Each pulse must appear
  // three clk cycles after the sclk edge that completed the byte (two
  // synchroniser flops plus the output register).
  always @(negedge clk) begin
    if (!rst) begin
      if (we) begin
        obs_wr.push_back({addr, wr_data});
        check("we_latency", cyc - last_rise_cyc, 3);
      end
      if (addr_err) begin
        obs_err++;
        check("err_latency", cyc - last_rise_cyc, 3);
      end
      if (frame_end) obs_fe++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      spi_mosi = b[7-i];
      tick(4);
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      tick(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic clear_obs();
    obs_wr.delete();
    obs_err = 0;
    obs_fe  = 0;
  endtask

  // Frame-level model: first byte is the address, every later byte is a
  // write to that address (or an error when out of range).
  task automatic model_frame();
    logic [7:0] a;
    exp_wr.delete();
    exp_err = 0;
    a = frame_q[0];
    for (int k = 1; k < frame_q.size(); k++) begin
      if (int'(a) < NREGS) begin
        exp_wr.push_back({a, frame_q[k]});
        hold_a = a;
        hold_d = frame_q[k];
      end else begin
        exp_err++;
      end
      if (AUTOINC && a != 8'hFF) a = a + 8'd1;
    end
  endtask

  task automatic compare_frame(input string name, input int exp_fe);
    int n;
    check({name, "_nwr"}, obs_wr.size(), exp_wr.size());
    n = (obs_wr.size() < exp_wr.size()) ? obs_wr.size() : exp_wr.size();
    for (int k = 0; k < n; k++) begin
      check({name, "_wr_addr"}, obs_wr[k][15:8], exp_wr[k][15:8]);
      check({name, "_wr_data"}, obs_wr[k][7:0], exp_wr[k][7:0]);
    end
    check({name, "_nerr"}, obs_err, exp_err);
    check({name, "_nfe"}, obs_fe, exp_fe);
    check({name, "_hold_addr"}, addr, hold_a);
    check({name, "_hold_data"}, wr_data, hold_d);
    $display("frame %s: bytes=%0d writes=%0d errs=%0d fe=%0d", name,
             frame_q.size(), obs_wr.size(), obs_err, obs_fe);
  endtask

  // Sends frame_q, optionally followed by a partial byte, then closes cs.
  task automatic run_frame(input string name, input int extra_bits);
    clear_obs();
    spi_cs_n = 1'b0;
    tick(4);
    foreach (frame_q[k]) send_bits(frame_q[k], 8);
    if (extra_bits > 0) send_bits(8'($urandom), extra_bits);
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
    model_frame();
    compare_frame(name, 1);
  endtask

  initial begin
    // Power-on reset.
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    check("rst_we", we, 0);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_addr_err", addr_err, 0);
    $display("reset: we=%0b addr=%0h wr_data=%0h", we, addr, wr_data);

    // Reset in the middle of a data byte: the rest of the frame is ignored.
    clear_obs();
    spi_cs_n = 1'b0;
    tick(4);
    send_bits(8'h03, 8);
    send_bits(8'h55, 4);
    rst = 1'b1;
    tick(3);
    check("midrst_we", we, 0);
    check("midrst_addr", addr, 0);
    check("midrst_wr_data", wr_data, 0);
    rst = 1'b0;
    send_bits(8'h5F, 4);
    send_bits(8'h77, 8);
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
    check("midrst_nwr", obs_wr.size(), 0);
    check("midrst_nerr", obs_err, 0);
    check("midrst_nfe", obs_fe, 0);
    $display("midframe reset: writes=%0d fe=%0d", obs_wr.size(), obs_fe);

    frame_q = '{8'h01, 8'hAA, 8'hBB, 8'hCC};
    run_frame("multi", 0);

    frame_q = '{8'h1E, 8'h11, 8'h22};
    run_frame("edge30", 0);

    frame_q = '{8'h05, 8'h12, 8'h34};
    run_frame("addr5", 0);

    frame_q = '{8'h02};
    run_frame("addronly_partial", 5);

    frame_q = '{8'h04, 8'h5A};
    run_frame("clean_after_partial", 0);

    frame_q = '{8'h40, 8'h99};
    run_frame("out_of_range", 0);

    frame_q = '{8'hFF, 8'h01, 8'h02};
    run_frame("saturate", 0);

    // sclk activity with cs high must not produce anything.
    clear_obs();
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 8);
    tick(8);
    check("csh_nwr", obs_wr.size(), 0);
    check("csh_nerr", obs_err, 0);
    check("csh_nfe", obs_fe, 0);
    check("csh_hold_addr", addr, hold_a);
    $display("sclk with cs high: writes=%0d errs=%0d fe=%0d", obs_wr.size(), obs_err, obs_fe);

    // Randomised frames.
    for (int f = 0; f < 24; f++) begin
      int nd;
      int extra;
      frame_q.delete();
      if ($urandom_range(0, 3) == 0) frame_q.push_back(8'($urandom_range(0, 255)));
      else                           frame_q.push_back(8'($urandom_range(0, 35)));
      nd = $urandom_range(0, 4);
      for (int k = 0; k < nd; k++) frame_q.push_back(8'($urandom));
      extra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 7) : 0;
      run_frame($sformatf("rand%0d", f), extra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
